// File: rtl/stream_split_pkg.sv
// Shared types and helpers for the stream_split_burst slice.
//
// Contents:
//   state_t     - burst FSM state encoding (START, ACTIVE, GAP)
//   clog2_min1  - $clog2 with a floor of 1 bit, used to size counters
//   LANE_W      - lane width of the default configuration
//   LEVEL_W     - fifo_level width of the default configuration
//
// Optional feature macro used by the top: STREAM_SPLIT_STATS_EN
package stream_split_pkg;

    typedef enum logic [1:0] {
        START  = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_FIFO_DEPTH = 4096;

    localparam int LANE_W  = DEF_DATA_WIDTH / DEF_NUM_CH;
    localparam int LEVEL_W = $clog2(DEF_FIFO_DEPTH + 1);

    // A counter that only ever holds 0 still needs one physical bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo_cnt.sv
// Synchronous FIFO with count-based full/empty so all DEPTH entries are usable.
//
// Ports:
//   clk, resetn      - clock, asynchronous active-low reset
//   push_valid       - upstream has a word
//   push_data        - upstream word
//   push_ready       - registered; high when the FIFO will not be full next cycle
//   pop              - consume the head word (ignored when empty)
//   pop_data         - head word (combinational read of the head entry)
//   empty            - level == 0
//   level            - current occupancy, 0..DEPTH
//
// Handshake: a push happens on a rising edge where push_valid && push_ready.
// push_ready is low whenever the FIFO is full, so a full FIFO never takes a
// word, even on a cycle where a pop frees an entry.
module sync_fifo_cnt
    import stream_split_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int DEPTH      = 4096,
    localparam int PTR_W      = clog2_min1(DEPTH),
    localparam int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ready,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty,
    output logic [LVL_W-1:0]      level
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level_next;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (level == '0);
    assign do_push  = push_valid && push_ready;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({do_push, do_pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
    end

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            push_ready <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level      <= level_next;
            push_ready <= (level_next != LVL_W'(DEPTH));
        end
    end

    // Storage is not reset: clearing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/stream_split_burst.sv
// Buffers a ready/valid word stream and replays it as NUM_CH parallel lanes in
// windows of ACTIVE_SAMPLES beats separated by IDLE_CYCLES idle cycles.
//
// Ports:
//   clk, resetn        - clock, asynchronous active-low reset
//   s_valid/s_data     - input stream; s_ready is registered (FIFO not full)
//   m_data             - lane c at m_data[c*LANE_W +: LANE_W]
//   m_valid            - per-lane valid, all bits identical
//   m_ready            - per-lane ready; a beat moves only when every lane is ready
//   burst_active       - FSM is in the ACTIVE window
//   fifo_level         - FIFO occupancy
//   stat_bursts        - completed windows        (only with STREAM_SPLIT_STATS_EN)
//   stat_stall_cycles  - ACTIVE backpressure cycles (only with STREAM_SPLIT_STATS_EN)
//
// Handshake: on both sides a beat transfers on a rising edge where valid and
// ready are both high; the sender holds data stable while valid && !ready.
module stream_split_burst
    import stream_split_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int ACTIVE_SAMPLES = 3276,
    parameter int IDLE_CYCLES    = 1172
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             s_valid,
    input  logic [DATA_WIDTH-1:0]            s_data,
    output logic                             s_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [NUM_CH-1:0]                m_valid,
    input  logic [NUM_CH-1:0]                m_ready,
    output logic                             burst_active,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
`ifdef STREAM_SPLIT_STATS_EN
    ,
    output logic [31:0]                      stat_bursts,
    output logic [31:0]                      stat_stall_cycles
`endif
);

    localparam int CH_W   = DATA_WIDTH / NUM_CH;
    localparam int BEAT_W = clog2_min1(ACTIVE_SAMPLES);
    localparam int IDLE_W = clog2_min1(IDLE_CYCLES);

    state_t              state;
    state_t              state_next;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                valid_q;
    logic [CH_W-1:0]     lane_q [NUM_CH];
    logic [DATA_WIDTH-1:0] head;
    logic                fifo_empty;
    logic                all_ready;
    logic                xfer;
    logic                last_beat;
    logic                gap_done;
    logic                pop;

    sync_fifo_cnt #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_valid (s_valid),
        .push_data  (s_data),
        .push_ready (s_ready),
        .pop        (pop),
        .pop_data   (head),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    assign all_ready = &m_ready;
    assign xfer      = valid_q && all_ready;
    assign last_beat = xfer && (beat_cnt == BEAT_W'(ACTIVE_SAMPLES - 1));
    assign gap_done  = (idle_cnt == IDLE_W'(IDLE_CYCLES - 1));

    // Refill the output register when it is empty or being drained, except on
    // the closing beat of a window: that word must wait for the next window.
    assign pop = (state == ACTIVE) && !fifo_empty && (!valid_q || xfer) && !last_beat;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= START;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            START:   state_next = ACTIVE;
            ACTIVE:  if (last_beat) state_next = GAP;
            GAP:     if (gap_done)  state_next = ACTIVE;
            default: state_next = START;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt <= '0;
            idle_cnt <= '0;
            valid_q  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) lane_q[c] <= '0;
        end else begin
            if (last_beat)  beat_cnt <= '0;
            else if (xfer)  beat_cnt <= beat_cnt + BEAT_W'(1);

            if (state == GAP) idle_cnt <= gap_done ? '0 : idle_cnt + IDLE_W'(1);

            // Output register is zero whenever it holds no beat, so GAP shows 0.
            if (pop) begin
                valid_q <= 1'b1;
                for (int c = 0; c < NUM_CH; c++) lane_q[c] <= head[c*CH_W +: CH_W];
            end else if (xfer) begin
                valid_q <= 1'b0;
                for (int c = 0; c < NUM_CH; c++) lane_q[c] <= '0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        assign m_data[g*CH_W +: CH_W] = lane_q[g];
        assign m_valid[g]             = valid_q;
    end

    assign burst_active = (state == ACTIVE);

`ifdef STREAM_SPLIT_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_bursts       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (last_beat) stat_bursts <= stat_bursts + 32'd1;
            if ((state == ACTIVE) && valid_q && !all_ready)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
